mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU instruction-fetch port and a data load/store port onto one
// single-outstanding memory backend, with a one-word instruction buffer.
module mem_arbiter #(
    parameter bit D_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_addr,
    input  logic        i_rstrb,
    output logic [31:0] i_rdata,
    output logic        i_rbusy,

    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    input  logic        d_wstrb,
    input  logic        d_rstrb,
    output logic [31:0] d_rdata,
    output logic        d_rbusy,
    output logic        d_wbusy,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned MW = 4;

    typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

    state_t state, state_n;

    logic          wp, rp, valid;
    logic [AW-1:0] wp_addr, wp_data, rp_addr, tag;
    logic [MW-1:0] wp_mask;

    logic          w_any, r_any, i_miss;
    logic [AW-1:0] w_addr_e, w_data_e, r_addr_e;
    logic [MW-1:0] w_mask_e;

    logic          req_n, we_n;
    logic [AW-1:0] addr_n, wdata_n;
    logic [MW-1:0] wmask_n;
    logic          fetch_done, load_done, store_done;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(3);
    endfunction

    // A strobe in the current cycle is served as if already pending
    assign w_any    = wp | d_wstrb;
    assign r_any    = rp | d_rstrb;
    assign w_addr_e = wp ? wp_addr : d_addr;
    assign w_data_e = wp ? wp_data : d_wdata;
    assign w_mask_e = wp ? wp_mask : d_wmask;
    assign r_addr_e = rp ? rp_addr : d_addr;

    assign d_wbusy = d_wstrb | wp;
    assign d_rbusy = d_rstrb | rp;
    assign i_rbusy = i_rstrb & ~(valid & (tag == i_addr));
    assign i_miss  = i_rbusy;

    // Next-state and next backend-bus values
    always_comb begin
        state_n    = state;
        req_n      = mem_req;
        we_n       = mem_we;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        wmask_n    = mem_wmask;
        fetch_done = 1'b0;
        load_done  = 1'b0;
        store_done = 1'b0;
        case (state)
            IDLE: begin
                if ((w_any || r_any) && (D_FIRST || !i_miss)) begin
                    req_n = 1'b1;
                    if (w_any) begin
                        state_n = DWRITE;
                        we_n    = 1'b1;
                        addr_n  = align(w_addr_e);
                        wdata_n = w_data_e;
                        wmask_n = w_mask_e;
                    end else begin
                        state_n = DREAD;
                        we_n    = 1'b0;
                        addr_n  = align(r_addr_e);
                        wdata_n = '0;
                        wmask_n = '0;
                    end
                end else if (i_miss) begin
                    state_n = IFETCH;
                    req_n   = 1'b1;
                    we_n    = 1'b0;
                    addr_n  = align(i_addr);
                    wdata_n = '0;
                    wmask_n = '0;
                end
            end
            IFETCH, DREAD, DWRITE: begin
                if (mem_ready) begin
                    state_n    = IDLE;
                    req_n      = 1'b0;
                    we_n       = 1'b0;
                    wmask_n    = '0;
                    fetch_done = (state == IFETCH);
                    load_done  = (state == DREAD);
                    store_done = (state == DWRITE);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered backend bus
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            state     <= state_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_wmask <= wmask_n;
        end
    end

    // Pending load/store slots; a strobe on an occupied slot is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= 1'b0;
            rp      <= 1'b0;
            wp_addr <= '0;
            wp_data <= '0;
            wp_mask <= '0;
            rp_addr <= '0;
            d_rdata <= '0;
        end else begin
            if (store_done) begin
                wp <= 1'b0;
            end else if (d_wstrb && !wp) begin
                wp      <= 1'b1;
                wp_addr <= d_addr;
                wp_data <= d_wdata;
                wp_mask <= d_wmask;
            end
            if (load_done) begin
                rp      <= 1'b0;
                d_rdata <= mem_rdata;
            end else if (d_rstrb && !rp) begin
                rp      <= 1'b1;
                rp_addr <= d_addr;
            end
        end
    end

    // Instruction buffer; stores hitting the buffered word invalidate it
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            tag     <= '0;
            i_rdata <= '0;
        end else if (fetch_done) begin
            valid   <= 1'b1;
            tag     <= mem_addr;
            i_rdata <= mem_rdata;
        end else if (store_done && (mem_addr[AW-1:2] == tag[AW-1:2])) begin
            valid   <= 1'b0;
        end
    end

endmodule
